// File: rtl/noc_pkg.sv
// Shared types for the mesh NoC route unit: direction codes, FSM states, routing modes.
package noc_pkg;

    typedef enum logic [2:0] {
        DIR_N    = 3'b000,
        DIR_S    = 3'b001,
        DIR_W    = 3'b010,
        DIR_E    = 3'b011,
        DIR_L    = 3'b100,
        DIR_NONE = 3'b111
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_LOCK
    } route_state_e;

    localparam logic ROUTE_YX = 1'b0;
    localparam logic ROUTE_XY = 1'b1;

    localparam int NUM_DIRS = 5;

endpackage

// File: rtl/dor_route_calc.sv
// Combinational dimension-order route decision (YX or XY) with out-of-mesh detection.
module dor_route_calc
    import noc_pkg::*;
#(
    parameter int COORD_W = 4,
    parameter int X_MAX   = 15,
    parameter int Y_MAX   = 15
) (
    input  logic [2*COORD_W-1:0] dest,
    input  logic [2*COORD_W-1:0] router_addr,
    input  logic                 mode,
    output dir_e                 dir,
    output logic                 addr_err
);

    logic [COORD_W-1:0] dx, dy, rx, ry;
    logic               x_gt, y_gt, x_ne, y_ne;

    assign dx = dest[2*COORD_W-1:COORD_W];
    assign dy = dest[COORD_W-1:0];
    assign rx = router_addr[2*COORD_W-1:COORD_W];
    assign ry = router_addr[COORD_W-1:0];

    assign x_gt = dx > rx;
    assign y_gt = dy > ry;
    assign x_ne = dx != rx;
    assign y_ne = dy != ry;

    // Widen before comparing so a mesh that fills the coordinate range stays a plain compare.
    assign addr_err = (32'(dx) > X_MAX) || (32'(dy) > Y_MAX);

    always_comb begin
        dir = DIR_L;
        if (addr_err || (!x_ne && !y_ne)) begin
            dir = DIR_L;
        end else if (mode == ROUTE_XY) begin
            if (x_ne) dir = x_gt ? DIR_E : DIR_W;
            else      dir = y_gt ? DIR_S : DIR_N;
        end else begin
            if (y_ne) dir = y_gt ? DIR_S : DIR_N;
            else      dir = x_gt ? DIR_E : DIR_W;
        end
    end

endmodule

// File: rtl/noc_route_unit.sv
// Per-input-port route unit: routes head flit, requests output, locks route until tail.
// Optional per-direction grant counters under ROUTE_STATS_EN.
module noc_route_unit
    import noc_pkg::*;
#(
    parameter int COORD_W = 4,
    parameter int X_MAX   = 15,
    parameter int Y_MAX   = 15,
    parameter int STAT_W  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [2*COORD_W-1:0]       router_addr_i,
    input  logic                       mode_i,
    input  logic                       flit_valid_i,
    input  logic                       flit_head_i,
    input  logic                       flit_tail_i,
    input  logic [2*COORD_W-1:0]       flit_dest_i,
    output logic                       flit_ready_o,
    output logic                       route_valid_o,
    output logic [2:0]                 route_o,
    input  logic                       route_ready_i,
    input  logic                       out_ready_i,
    output logic                       pkt_active_o,
    output logic                       err_o,
    output logic [NUM_DIRS*STAT_W-1:0] stat_cnt_o
);

    route_state_e state;
    dir_e         calc_dir;
    logic         calc_err;
    logic         flit_acc;
    logic         head_seen;

    dor_route_calc #(
        .COORD_W(COORD_W),
        .X_MAX  (X_MAX),
        .Y_MAX  (Y_MAX)
    ) u_calc (
        .dest       (flit_dest_i),
        .router_addr(router_addr_i),
        .mode       (mode_i),
        .dir        (calc_dir),
        .addr_err   (calc_err)
    );

    // Stray non-head flits in IDLE are accepted so they drain instead of blocking the port.
    always_comb begin
        flit_ready_o = 1'b0;
        case (state)
            ST_IDLE: flit_ready_o = flit_valid_i && !flit_head_i;
            ST_LOCK: flit_ready_o = out_ready_i;
            default: flit_ready_o = 1'b0;
        endcase
        if (!rst_ni) flit_ready_o = 1'b0;
    end

    assign flit_acc = flit_valid_i && flit_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= ST_IDLE;
            route_valid_o <= 1'b0;
            route_o       <= DIR_NONE;
            pkt_active_o  <= 1'b0;
            err_o         <= 1'b0;
            head_seen     <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (flit_valid_i && flit_head_i) begin
                        state         <= ST_REQ;
                        route_o       <= calc_dir;
                        route_valid_o <= 1'b1;
                        err_o         <= calc_err;
                    end else if (flit_acc) begin
                        err_o <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (route_ready_i) begin
                        state         <= ST_LOCK;
                        route_valid_o <= 1'b0;
                        pkt_active_o  <= 1'b1;
                        head_seen     <= 1'b0;
                    end
                end
                ST_LOCK: begin
                    if (flit_acc) begin
                        head_seen <= 1'b1;
                        // The first flit through is the packet's own head; any later head means a lost tail.
                        if (flit_head_i && head_seen) err_o <= 1'b1;
                        if (flit_tail_i) begin
                            state        <= ST_IDLE;
                            pkt_active_o <= 1'b0;
                            route_o      <= DIR_NONE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ROUTE_STATS_EN
    logic [NUM_DIRS-1:0][STAT_W-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (state == ST_REQ && route_ready_i) begin
            for (int d = 0; d < NUM_DIRS; d++) begin
                if (route_o == 3'(d) && cnt[d] != '1) cnt[d] <= cnt[d] + 1'b1;
            end
        end
    end

    assign stat_cnt_o = cnt;
`else
    assign stat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_noc_route_unit.sv
// Directed self-checking bench for noc_route_unit (X_MAX=7, STAT_W=2).
module tb_noc_route_unit;
    localparam int COORD_W = 4;
    localparam int STAT_W  = 2;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [7:0]           router_addr_i;
    logic                 mode_i;
    logic                 flit_valid_i;
    logic                 flit_head_i;
    logic                 flit_tail_i;
    logic [7:0]           flit_dest_i;
    logic                 flit_ready_o;
    logic                 route_valid_o;
    logic [2:0]           route_o;
    logic                 route_ready_i;
    logic                 out_ready_i;
    logic                 pkt_active_o;
    logic                 err_o;
    logic [5*STAT_W-1:0]  stat_cnt_o;

    int n_chk = 0;
    int n_err = 0;

    noc_route_unit #(
        .COORD_W(COORD_W),
        .X_MAX  (7),
        .Y_MAX  (15),
        .STAT_W (STAT_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .router_addr_i(router_addr_i),
        .mode_i       (mode_i),
        .flit_valid_i (flit_valid_i),
        .flit_head_i  (flit_head_i),
        .flit_tail_i  (flit_tail_i),
        .flit_dest_i  (flit_dest_i),
        .flit_ready_o (flit_ready_o),
        .route_valid_o(route_valid_o),
        .route_o      (route_o),
        .route_ready_i(route_ready_i),
        .out_ready_i  (out_ready_i),
        .pkt_active_o (pkt_active_o),
        .err_o        (err_o),
        .stat_cnt_o   (stat_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    // Single-flit packet: IDLE -> REQ -> LOCK -> accepted -> IDLE.
    task automatic send_pkt(input logic [7:0] dest, input logic mode, input logic [2:0] exp_route,
                            input logic exp_err);
        flit_valid_i = 1; flit_head_i = 1; flit_tail_i = 1;
        flit_dest_i = dest; mode_i = mode; route_ready_i = 0; out_ready_i = 1;
        @(negedge clk_i);
        chk("idle_rv", 32'(route_valid_o), 0);
        chk("idle_rdy", 32'(flit_ready_o), 0);
        chk("idle_route", 32'(route_o), 7);
        chk("idle_act", 32'(pkt_active_o), 0);
        nxt();
        route_ready_i = 1;
        @(negedge clk_i);
        chk("req_rv", 32'(route_valid_o), 1);
        chk("req_route", 32'(route_o), 32'(exp_route));
        chk("req_err", 32'(err_o), 32'(exp_err));
        chk("req_rdy", 32'(flit_ready_o), 0);
        nxt();
        route_ready_i = 0;
        @(negedge clk_i);
        chk("lock_act", 32'(pkt_active_o), 1);
        chk("lock_rdy", 32'(flit_ready_o), 1);
        chk("lock_route", 32'(route_o), 32'(exp_route));
        chk("lock_rv", 32'(route_valid_o), 0);
        nxt();
        flit_valid_i = 0; flit_head_i = 0; flit_tail_i = 0;
    endtask

    initial begin
        int pat [6] = '{1, 0, 1, 1, 0, 1};
        int k;
        logic [5*STAT_W-1:0] exp_stat;

        rst_ni = 0; router_addr_i = 8'h22; mode_i = 0;
        flit_valid_i = 0; flit_head_i = 0; flit_tail_i = 0; flit_dest_i = 0;
        route_ready_i = 0; out_ready_i = 0;
        #12;
        chk("rst_rdy", 32'(flit_ready_o), 0);
        chk("rst_rv", 32'(route_valid_o), 0);
        chk("rst_route", 32'(route_o), 7);
        chk("rst_act", 32'(pkt_active_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_stat", 32'(stat_cnt_o), 0);
        @(negedge clk_i);
        rst_ni = 1;
        nxt();

        // YX: dest 0x25 from 0x22 -> S
        send_pkt(8'h25, 0, 3'b001, 0);

        // 4-flit packet toward S with out_ready toggling
        flit_valid_i = 1; flit_head_i = 1; flit_tail_i = 0;
        flit_dest_i = 8'h25; mode_i = 0; out_ready_i = 0; route_ready_i = 0;
        @(negedge clk_i);
        chk("p4_idle_rv", 32'(route_valid_o), 0);
        nxt();
        route_ready_i = 1;
        @(negedge clk_i);
        chk("p4_req_rv", 32'(route_valid_o), 1);
        chk("p4_req_route", 32'(route_o), 1);
        nxt();
        route_ready_i = 0;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            out_ready_i = pat[i][0];
            flit_head_i = (k == 0);
            flit_tail_i = (k == 3);
            flit_dest_i = (k == 0) ? 8'h25 : 8'hff;
            @(negedge clk_i);
            chk("p4_rdy", 32'(flit_ready_o), 32'(pat[i]));
            chk("p4_route", 32'(route_o), 1);
            chk("p4_act", 32'(pkt_active_o), 1);
            chk("p4_err", 32'(err_o), 0);
            nxt();
            if (pat[i] != 0) k++;
        end
        chk("p4_flits", 32'(k), 4);
        flit_valid_i = 0; flit_head_i = 0; flit_tail_i = 0;

        // Back-to-back head the cycle after the tail; XY -> E
        send_pkt(8'h35, 1, 3'b011, 0);
        send_pkt(8'h35, 0, 3'b001, 0);
        send_pkt(8'h22, 0, 3'b100, 0);
        // x=9 beyond X_MAX=7 -> eject with error
        send_pkt(8'h93, 0, 3'b100, 1);

`ifdef ROUTE_STATS_EN
        exp_stat = 10'h24C;
`else
        exp_stat = '0;
`endif
        chk("stat_mix", 32'(stat_cnt_o), 32'(exp_stat));

        // Body flit in IDLE: dropped, single err pulse
        flit_valid_i = 1; flit_head_i = 0; flit_tail_i = 0;
        @(negedge clk_i);
        chk("body_rdy", 32'(flit_ready_o), 1);
        chk("body_err0", 32'(err_o), 0);
        nxt();
        flit_valid_i = 0;
        @(negedge clk_i);
        chk("body_err1", 32'(err_o), 1);
        chk("body_rv", 32'(route_valid_o), 0);
        nxt();
        @(negedge clk_i);
        chk("body_err2", 32'(err_o), 0);
        nxt();

        // Reset asserted during LOCK
        flit_valid_i = 1; flit_head_i = 1; flit_tail_i = 0;
        flit_dest_i = 8'h25; mode_i = 0; out_ready_i = 1; route_ready_i = 0;
        nxt();
        route_ready_i = 1;
        nxt();
        route_ready_i = 0;
        @(negedge clk_i);
        chk("rl_act", 32'(pkt_active_o), 1);
        nxt();
        flit_head_i = 0;
        #2;
        rst_ni = 0;
        #1;
        chk("rl_rdy", 32'(flit_ready_o), 0);
        chk("rl_rv", 32'(route_valid_o), 0);
        chk("rl_route", 32'(route_o), 7);
        chk("rl_act0", 32'(pkt_active_o), 0);
        chk("rl_err", 32'(err_o), 0);
        chk("rl_stat", 32'(stat_cnt_o), 0);
        @(negedge clk_i);
        rst_ni = 1;
        nxt();
        @(negedge clk_i);
        chk("rl_drop_rdy", 32'(flit_ready_o), 1);
        nxt();
        flit_tail_i = 1;
        nxt();
        flit_valid_i = 0; flit_tail_i = 0;
        @(negedge clk_i);
        chk("rl_drop_err", 32'(err_o), 1);
        nxt();

        // Recovery, then five S packets in total to saturate the S counter
        for (int i = 0; i < 5; i++) send_pkt(8'h25, 0, 3'b001, 0);

`ifdef ROUTE_STATS_EN
        exp_stat = 10'h00C;
`else
        exp_stat = '0;
`endif
        @(negedge clk_i);
        chk("stat_sat", 32'(stat_cnt_o), 32'(exp_stat));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
